uart_tx_param: RTL and testbench

//  Parametrised UART transmitter; successor to the fixed 8-bit/parity-only TX path.

---
 rtl/uart_tx_param.sv | 156 +++++++++++++++
 tb/tb_uart_tx_param.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: baud divider, parity generator, frame shifter and
// ready/valid handshake. Frame = start, DATA_BITS (LSB first), optional parity, stop bit(s).
module uart_tx_param #(
   parameter int unsigned DATA_BITS = 8,
   parameter int unsigned CLK_DIV   = 434,
   parameter int unsigned PARITY_EN = 1,
   parameter int unsigned STOP_BITS = 1
) (
   input  logic                 Clk,
   input  logic                 Rst,
   input  logic                 ParitySelect,
   input  logic                 Send,
   input  logic [DATA_BITS-1:0] Din,
   output logic                 Ready,
   output logic                 Busy,
   output logic                 Done,
   output logic                 out
);

   localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int unsigned BIT_W = $clog2(DATA_BITS + 1);
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLK_DIV - 1);
   localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_BITS - 1);
   localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);

   if (DATA_BITS < 5 || DATA_BITS > 9 || CLK_DIV < 2 || PARITY_EN > 1 ||
       STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_param
      $error("uart_tx_param: illegal parameter value");
   end

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4
   } state_t;

   state_t                 r_state, w_state;
   logic [CNT_W-1:0]       r_cnt, w_cnt;
   logic [BIT_W-1:0]       r_bit, w_bit;
   logic [DATA_BITS-1:0]   r_shift, w_shift;
   logic                   r_par, w_par;
   logic                   r_out, w_out;
   logic                   r_ready, w_ready;
   logic                   r_busy;
   logic                   r_done, w_done;
   logic                   w_adv;

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_bit   <= '0;
         r_shift <= '0;
         r_par   <= 1'b0;
         r_out   <= 1'b1;
         r_ready <= 1'b1;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state;
         r_cnt   <= w_cnt;
         r_bit   <= w_bit;
         r_shift <= w_shift;
         r_par   <= w_par;
         r_out   <= w_out;
         r_ready <= w_ready;
         r_busy  <= ~w_ready;
         r_done  <= w_done;
      end
   end

   assign w_adv = (r_cnt == CNT_LAST);

   // The line value for the next bit is loaded on the advancing edge, so the shifter
   // always holds the not-yet-sent bits with the next one at index 0.
   always_comb begin
      w_state = r_state;
      w_cnt   = r_cnt;
      w_bit   = r_bit;
      w_shift = r_shift;
      w_par   = r_par;
      w_out   = r_out;
      w_ready = r_ready;
      w_done  = 1'b0;
      if (r_state != S_IDLE) begin
         w_cnt = w_adv ? '0 : r_cnt + 1'b1;
      end
      case (r_state)
         S_IDLE: begin
            if (Send && r_ready) begin
               w_shift = Din;
               w_par   = (^Din) ^ ParitySelect;
               w_state = S_START;
               w_out   = 1'b0;
               w_ready = 1'b0;
               w_cnt   = '0;
               w_bit   = '0;
            end
         end
         S_START: begin
            if (w_adv) begin
               w_state = S_DATA;
               w_out   = r_shift[0];
               w_shift = r_shift >> 1;
               w_bit   = '0;
            end
         end
         S_DATA: begin
            if (w_adv) begin
               if (r_bit == DATA_LAST) begin
                  w_bit = '0;
                  if (PARITY_EN == 1) begin
                     w_state = S_PARITY;
                     w_out   = r_par;
                  end else begin
                     w_state = S_STOP;
                     w_out   = 1'b1;
                  end
               end else begin
                  w_out   = r_shift[0];
                  w_shift = r_shift >> 1;
                  w_bit   = r_bit + 1'b1;
               end
            end
         end
         S_PARITY: begin
            if (w_adv) begin
               w_state = S_STOP;
               w_out   = 1'b1;
               w_bit   = '0;
            end
         end
         S_STOP: begin
            if (w_adv) begin
               if (r_bit == STOP_LAST) begin
                  w_state = S_IDLE;
                  w_ready = 1'b1;
                  w_done  = 1'b1;
                  w_bit   = '0;
               end else begin
                  w_bit = r_bit + 1'b1;
               end
            end
         end
         default: w_state = S_IDLE;
      endcase
   end

   assign Ready = r_ready;
   assign Busy  = r_busy;
   assign Done  = r_done;
   assign out   = r_out;

endmodule

// File: tb/tb_uart_tx_param.sv
// Bench for uart_tx_param: three configurations, directed frame table, reset abort,
// and random frames checked cycle by cycle against a bit-list frame model.
module tb_uart_tx_param;

   localparam int unsigned NDUT = 3;
   localparam int unsigned DB [NDUT] = '{8, 7, 8};
   localparam int unsigned DIV[NDUT] = '{4, 4, 2};
   localparam int unsigned PE [NDUT] = '{1, 0, 1};
   localparam int unsigned SB [NDUT] = '{1, 2, 1};

   logic       Clk = 1'b0;
   logic       Rst;
   logic       send_v [NDUT];
   logic       ps_v   [NDUT];
   logic [8:0] din_v  [NDUT];
   logic       w_out  [NDUT];
   logic       w_ready[NDUT];
   logic       w_busy [NDUT];
   logic       w_done [NDUT];

   int total = 0;
   int bad   = 0;

   always #5 Clk = ~Clk;

   uart_tx_param #(.DATA_BITS(DB[0]), .CLK_DIV(DIV[0]), .PARITY_EN(PE[0]), .STOP_BITS(SB[0])) u_a (
      .Clk(Clk), .Rst(Rst), .ParitySelect(ps_v[0]), .Send(send_v[0]), .Din(din_v[0][7:0]),
      .Ready(w_ready[0]), .Busy(w_busy[0]), .Done(w_done[0]), .out(w_out[0]));

   uart_tx_param #(.DATA_BITS(DB[1]), .CLK_DIV(DIV[1]), .PARITY_EN(PE[1]), .STOP_BITS(SB[1])) u_b (
      .Clk(Clk), .Rst(Rst), .ParitySelect(ps_v[1]), .Send(send_v[1]), .Din(din_v[1][6:0]),
      .Ready(w_ready[1]), .Busy(w_busy[1]), .Done(w_done[1]), .out(w_out[1]));

   uart_tx_param #(.DATA_BITS(DB[2]), .CLK_DIV(DIV[2]), .PARITY_EN(PE[2]), .STOP_BITS(SB[2])) u_c (
      .Clk(Clk), .Rst(Rst), .ParitySelect(ps_v[2]), .Send(send_v[2]), .Din(din_v[2][7:0]),
      .Ready(w_ready[2]), .Busy(w_busy[2]), .Done(w_done[2]), .out(w_out[2]));

   typedef struct {
      int         d;
      logic [8:0] din;
      logic       ps;
      bit         hold;
      logic [8:0] din_mid;
      logic       ps_mid;
      bit         poke;
      logic [15:0] exp_bits;
      int         exp_len;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   // Frame as a list of line levels: start, data LSB first, parity, stop bits.
   function automatic logic [15:0] model_bits(input int d, input logic [8:0] din, input logic ps);
      logic [15:0] v;
      int pos;
      int ones;
      v    = '0;
      pos  = 1;
      ones = 0;
      for (int i = 0; i < int'(DB[d]); i++) begin
         v[pos] = din[i];
         ones += int'(din[i]);
         pos++;
      end
      if (PE[d] == 1) begin
         v[pos] = ((ones % 2) == 1) ^ ps;
         pos++;
      end
      for (int s = 0; s < int'(SB[d]); s++) begin
         v[pos] = 1'b1;
         pos++;
      end
      return v;
   endfunction

   function automatic int model_len(input int d);
      return int'((1 + DB[d] + PE[d] + SB[d]) * DIV[d]);
   endfunction

   task automatic idle_check(input int d, input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge Clk);
         chk($sformatf("dut%0d idle out", d), w_out[d], 1);
         chk($sformatf("dut%0d idle ready", d), w_ready[d], 1);
         chk($sformatf("dut%0d idle busy", d), w_busy[d], 0);
         chk($sformatf("dut%0d idle done", d), w_done[d], 0);
      end
   endtask

   // Called at a negedge; the accept happens on the following posedge.
   task automatic run_frame(input int d, input logic [8:0] din, input logic ps,
                            input logic [15:0] bits, input int len, input bit hold,
                            input logic [8:0] din_mid, input logic ps_mid, input bit poke);
      logic exp_out;
      chk($sformatf("dut%0d ready before send", d), w_ready[d], 1);
      din_v[d]  = din;
      ps_v[d]   = ps;
      send_v[d] = 1'b1;
      for (int k = 0; k < len; k++) begin
         @(negedge Clk);
         exp_out = bits[k / int'(DIV[d])];
         chk($sformatf("dut%0d out k=%0d", d, k), w_out[d], exp_out);
         chk($sformatf("dut%0d ready k=%0d", d, k), w_ready[d], 0);
         chk($sformatf("dut%0d busy k=%0d", d, k), w_busy[d], 1);
         chk($sformatf("dut%0d done k=%0d", d, k), w_done[d], 0);
         if (k == 0 && !hold) send_v[d] = 1'b0;
         if (k == len / 2) begin
            din_v[d] = din_mid;
            ps_v[d]  = ps_mid;
            if (poke) send_v[d] = 1'b1;
         end
         if (poke && k == len / 2 + 1) send_v[d] = 1'b0;
      end
      @(negedge Clk);
      chk($sformatf("dut%0d done at end", d), w_done[d], 1);
      chk($sformatf("dut%0d ready at end", d), w_ready[d], 1);
      chk($sformatf("dut%0d busy at end", d), w_busy[d], 0);
      chk($sformatf("dut%0d out at end", d), w_out[d], 1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t        vecs[6];
      logic [15:0] bits;
      int          d;
      logic [8:0]  din, nd;
      logic        ps, np;
      bit          hold, pend, poke;

      vecs[0] = '{d:0, din:9'hA5, ps:0, hold:0, din_mid:9'h0FF, ps_mid:1, poke:0, exp_bits:16'h054A, exp_len:44};
      vecs[1] = '{d:0, din:9'h00, ps:1, hold:0, din_mid:9'h055, ps_mid:0, poke:1, exp_bits:16'h0600, exp_len:44};
      vecs[2] = '{d:0, din:9'h3C, ps:0, hold:1, din_mid:9'h0FF, ps_mid:1, poke:0, exp_bits:16'h0478, exp_len:44};
      vecs[3] = '{d:0, din:9'hFF, ps:1, hold:0, din_mid:9'h0FF, ps_mid:1, poke:0, exp_bits:16'h07FE, exp_len:44};
      vecs[4] = '{d:1, din:9'h41, ps:0, hold:0, din_mid:9'h03F, ps_mid:1, poke:0, exp_bits:16'h0382, exp_len:40};
      vecs[5] = '{d:2, din:9'h5A, ps:1, hold:0, din_mid:9'h000, ps_mid:0, poke:1, exp_bits:16'h06B4, exp_len:22};

      Rst = 1'b0;
      for (int i = 0; i < int'(NDUT); i++) begin
         send_v[i] = 1'b0;
         ps_v[i]   = 1'b0;
         din_v[i]  = '0;
      end
      repeat (3) @(negedge Clk);
      for (int i = 0; i < int'(NDUT); i++) begin
         chk($sformatf("dut%0d reset out", i), w_out[i], 1);
         chk($sformatf("dut%0d reset ready", i), w_ready[i], 1);
         chk($sformatf("dut%0d reset busy", i), w_busy[i], 0);
         chk($sformatf("dut%0d reset done", i), w_done[i], 0);
      end
      Rst = 1'b1;

      for (int v = 0; v < 6; v++) begin
         run_frame(vecs[v].d, vecs[v].din, vecs[v].ps, vecs[v].exp_bits, vecs[v].exp_len,
                   vecs[v].hold, vecs[v].din_mid, vecs[v].ps_mid, vecs[v].poke);
         if (!vecs[v].hold) idle_check(vecs[v].d, 3);
      end

      // Abort a frame with reset during data bit 3 (frame slots 16..19 on dut0).
      bits = model_bits(0, 9'h0C3, 1'b0);
      din_v[0]  = 9'h0C3;
      ps_v[0]   = 1'b0;
      send_v[0] = 1'b1;
      for (int k = 0; k <= 17; k++) begin
         @(negedge Clk);
         chk($sformatf("abort out k=%0d", k), w_out[0], bits[k / 4]);
         if (k == 0) send_v[0] = 1'b0;
      end
      #1 Rst = 1'b0;
      #1;
      chk("abort async out", w_out[0], 1);
      chk("abort async ready", w_ready[0], 1);
      chk("abort async busy", w_busy[0], 0);
      chk("abort async done", w_done[0], 0);
      @(negedge Clk);
      chk("abort held done", w_done[0], 0);
      chk("abort held out", w_out[0], 1);
      Rst = 1'b1;
      idle_check(0, 4);
      run_frame(0, 9'h0C3, 1'b1, model_bits(0, 9'h0C3, 1'b1), model_len(0), 0, 9'h000, 1'b0, 0);
      idle_check(0, 2);

      pend = 0;
      d    = 0;
      din  = '0;
      ps   = 1'b0;
      nd   = '0;
      np   = 1'b0;
      for (int i = 0; i < 30; i++) begin
         if (!pend) begin
            d   = int'($urandom_range(0, 2));
            din = 9'($urandom);
            ps  = 1'($urandom);
         end else begin
            din = nd;
            ps  = np;
         end
         hold = (i < 29) && ($urandom_range(0, 3) == 0);
         poke = !hold && ($urandom_range(0, 3) == 0);
         nd   = 9'($urandom);
         np   = 1'($urandom);
         run_frame(d, din, ps, model_bits(d, din, ps), model_len(d), hold, nd, np, poke);
         if (poke) idle_check(d, 2);
         pend = hold;
      end
      idle_check(0, 2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
